segasys1_vtiming: RTL and testbench



---
 rtl/segasys1_vtiming.sv | 162 ++++++++++++++++
 tb/tb_segasys1_vtiming.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/segasys1_vtiming.sv
`default_nettype none
// ============================================================================
//  Module      : segasys1_vtiming
//  Description : System 1/2 video timing generator and pixel output stage.
//                Divides clk48M to a 6 MHz pixel enable, runs the PH/PV beam
//                counters, captures POUT once per pixel and drives expanded
//                24-bit RGB with blanking and syncs.
//  Revision    : 1.0 - initial release
// ============================================================================
module segasys1_vtiming #(
   parameter int HTOTAL   = 384,
   parameter int HACT     = 256,
   parameter int HS_START = 304,
   parameter int HS_LEN   = 32,
   parameter int VTOTAL   = 264,
   parameter int VACT     = 224,
   parameter int VS_START = 236,
   parameter int VS_LEN   = 3
) (
   input  logic       clk48M,
   input  logic       reset_n,
   input  logic [3:0] HOFFS,
   input  logic [7:0] POUT,
   output logic [8:0] PH,
   output logic [8:0] PV,
   output logic       CE_PIX,
   output logic [7:0] R,
   output logic [7:0] G,
   output logic [7:0] B,
   output logic       HBLANK,
   output logic       VBLANK,
   output logic       HSYNC,
   output logic       VSYNC
);

   localparam logic [8:0]        c_h_last   = 9'(HTOTAL - 1);
   localparam logic [8:0]        c_v_last   = 9'(VTOTAL - 1);
   localparam logic [8:0]        c_hact     = 9'(HACT);
   localparam logic [8:0]        c_vact     = 9'(VACT);
   localparam logic [8:0]        c_vs_start = 9'(VS_START);
   localparam logic [8:0]        c_vs_end   = 9'(VS_START + VS_LEN);
   localparam logic signed [9:0] c_hs_start = 10'(HS_START);
   localparam logic signed [9:0] c_hs_len   = 10'(HS_LEN);

   logic [2:0] r_div;
   logic       r_ce;
   logic [8:0] r_ph;
   logic [8:0] r_pv;
   logic [3:0] r_hoffs;

   logic       r_hb;
   logic       r_vb;
   logic       r_hs;
   logic       r_vs;
   logic [7:0] r_r;
   logic [7:0] r_g;
   logic [7:0] r_b;

   logic              w_h_last;
   logic              w_v_last;
   logic signed [9:0] w_hoffs_x4;
   logic signed [9:0] w_hs0;
   logic signed [9:0] w_ph_s;
   logic              w_hb;
   logic              w_vb;
   logic              w_hs;
   logic              w_vs;
   logic [2:0]        w_pr;
   logic [2:0]        w_pg;
   logic [1:0]        w_pb;

   assign w_h_last = (r_ph == c_h_last);
   assign w_v_last = (r_pv == c_v_last);

   // Offset is in units of 4 pixels; sign-extend and scale to 10-bit signed.
   assign w_hoffs_x4 = {{4{r_hoffs[3]}}, r_hoffs, 2'b00};
   assign w_hs0      = c_hs_start + w_hoffs_x4;
   assign w_ph_s     = {1'b0, r_ph};

   assign w_hb = (r_ph >= c_hact);
   assign w_vb = (r_pv >= c_vact);
   assign w_hs = (w_ph_s >= w_hs0) && (w_ph_s < (w_hs0 + c_hs_len));
   assign w_vs = (r_pv >= c_vs_start) && (r_pv < c_vs_end);

   assign w_pr = POUT[2:0];
   assign w_pg = POUT[5:3];
   assign w_pb = POUT[7:6];

   // Pixel divider; the enable is registered one count early so that it is
   // high exactly while the divider sits at 7 and is glitch-free.
   always_ff @(posedge clk48M or negedge reset_n) begin
      if (!reset_n) begin
         r_div <= 3'd0;
         r_ce  <= 1'b0;
      end else begin
         r_div <= r_div + 3'd1;
         r_ce  <= (r_div == 3'd6);
      end
   end

   // Beam counters; the sync offset is latched only at frame start so a
   // mid-frame change never produces a torn line.
   always_ff @(posedge clk48M or negedge reset_n) begin
      if (!reset_n) begin
         r_ph    <= 9'd0;
         r_pv    <= 9'd0;
         r_hoffs <= 4'd0;
      end else if (r_ce) begin
         if (w_h_last) begin
            r_ph <= 9'd0;
            if (w_v_last) begin
               r_pv    <= 9'd0;
               r_hoffs <= HOFFS;
            end else begin
               r_pv <= r_pv + 9'd1;
            end
         end else begin
            r_ph <= r_ph + 9'd1;
         end
      end
   end

   // Output stage: flags and colour for the pre-increment beam position.
   always_ff @(posedge clk48M or negedge reset_n) begin
      if (!reset_n) begin
         r_hb <= 1'b0;
         r_vb <= 1'b0;
         r_hs <= 1'b0;
         r_vs <= 1'b0;
         r_r  <= 8'd0;
         r_g  <= 8'd0;
         r_b  <= 8'd0;
      end else if (r_ce) begin
         r_hb <= w_hb;
         r_vb <= w_vb;
         r_hs <= w_hs;
         r_vs <= w_vs;
         if (w_hb || w_vb) begin
            r_r <= 8'd0;
            r_g <= 8'd0;
            r_b <= 8'd0;
         end else begin
            r_r <= {w_pr, w_pr, w_pr[2:1]};
            r_g <= {w_pg, w_pg, w_pg[2:1]};
            r_b <= {w_pb, w_pb, w_pb, w_pb};
         end
      end
   end

   assign PH     = r_ph;
   assign PV     = r_pv;
   assign CE_PIX = r_ce;
   assign R      = r_r;
   assign G      = r_g;
   assign B      = r_b;
   assign HBLANK = r_hb;
   assign VBLANK = r_vb;
   assign HSYNC  = r_hs;
   assign VSYNC  = r_vs;

endmodule
`default_nettype wire

// File: tb/tb_segasys1_vtiming.sv
`default_nettype none
// ============================================================================
//  Module      : tb_segasys1_vtiming
//  Description : Directed self-checking bench for segasys1_vtiming. The
//                vertical geometry is shrunk (6 lines, 3 active, VSYNC on
//                lines 3..4) so whole frames fit in a short run; horizontal
//                timing keeps its real values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_segasys1_vtiming;

   localparam int c_LINE  = 3072;
   localparam int c_FRAME = 6 * c_LINE;
   localparam int c_LIMIT = 20000;

   logic       clk48M;
   logic       reset_n;
   logic [3:0] HOFFS;
   logic [7:0] POUT;
   logic [8:0] PH;
   logic [8:0] PV;
   logic       CE_PIX;
   logic [7:0] R;
   logic [7:0] G;
   logic [7:0] B;
   logic       HBLANK;
   logic       VBLANK;
   logic       HSYNC;
   logic       VSYNC;

   int n_checks = 0;
   int n_pass   = 0;

   segasys1_vtiming #(
      .VTOTAL   (6),
      .VACT     (3),
      .VS_START (3),
      .VS_LEN   (2)
   ) dut (
      .clk48M  (clk48M),
      .reset_n (reset_n),
      .HOFFS   (HOFFS),
      .POUT    (POUT),
      .PH      (PH),
      .PV      (PV),
      .CE_PIX  (CE_PIX),
      .R       (R),
      .G       (G),
      .B       (B),
      .HBLANK  (HBLANK),
      .VBLANK  (VBLANK),
      .HSYNC   (HSYNC),
      .VSYNC   (VSYNC)
   );

   initial clk48M = 1'b0;
   always #5 clk48M = ~clk48M;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock, sampling 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk48M);
      #1;
   endtask

   // Stop in the cycle whose closing edge captures pixel (ph, pv).
   task automatic wait_pos(input int ph, input int pv);
      int n;
      n = 0;
      while (!(CE_PIX === 1'b1 && PH == 9'(ph) && PV == 9'(pv)) && n < c_LIMIT) begin
         tick();
         n++;
      end
      check("wait_bound", 64'(n < c_LIMIT), 64'd1);
   endtask

   // Find where HSYNC starts and how many pixels it covers on one line.
   task automatic scan_line(input int line, output int first, output int cnt);
      first = -1;
      cnt   = 0;
      wait_pos(0, line);
      for (int p = 0; p < 384; p++) begin
         tick();
         if (HSYNC) begin
            if (first < 0) first = p;
            cnt++;
         end
         if (p < 383) repeat (7) tick();
      end
   endtask

   initial begin
      logic [15:0] ce_pat;
      int          hs_rise, vs_rise, vs_clks, first, cnt;
      logic        prev_hs, prev_vs;

      reset_n = 1'b0;
      HOFFS   = 4'h0;
      POUT    = 8'h00;
      ce_pat  = '0;
      hs_rise = 0;
      vs_rise = 0;
      vs_clks = 0;
      prev_hs = 1'b0;
      prev_vs = 1'b0;

      repeat (5) @(posedge clk48M);
      #1;
      check("reset_state", 64'({PH, PV, CE_PIX, R, G, B, HBLANK, VBLANK, HSYNC, VSYNC}), 64'd0);

      @(negedge clk48M);
      reset_n = 1'b1;

      // Frame 0: latched offset is still 0, so HSYNC sits at 304..335.
      for (int i = 1; i <= c_FRAME; i++) begin
         tick();
         if (i == 1) HOFFS = 4'h8;
         if (i <= 16) ce_pat[i-1] = CE_PIX;
         if (HSYNC && !prev_hs) hs_rise++;
         if (VSYNC && !prev_vs) vs_rise++;
         if (VSYNC) vs_clks++;
         prev_hs = HSYNC;
         prev_vs = VSYNC;
         if (i == c_LINE) check("line_wrap", 64'({PH, PV}), 64'({9'd0, 9'd1}));
      end
      // CE_PIX high during clocks 8 and 16 (seen just after edges 7 and 15).
      check("ce_pattern", 64'(ce_pat), 64'h4040);
      check("frame_wrap", 64'({PH, PV}), 64'd0);
      check("hs_rises", 64'(hs_rise), 64'd6);
      check("vs_rises", 64'(vs_rise), 64'd1);
      check("vs_width_clks", 64'(vs_clks), 64'(2 * c_LINE));

      // Colour expansion on frame 1, line 0.
      POUT = 8'hFF;
      wait_pos(10, 0);
      tick();
      check("rgb_white", 64'({R, G, B}), 64'hFFFFFF);
      check("blank_white", 64'({HBLANK, VBLANK}), 64'd0);

      POUT = 8'b01_101_011;
      wait_pos(11, 0);
      tick();
      POUT = 8'h00;
      check("rgb_expand", 64'({R, G, B}), 64'h6DB655);
      repeat (7) tick();
      check("rgb_hold", 64'({R, G, B}), 64'h6DB655);

      // Horizontal blanking boundary.
      POUT = 8'hFF;
      wait_pos(255, 0);
      tick();
      check("hb_255", 64'({HBLANK, R}), 64'h0FF);
      wait_pos(256, 0);
      tick();
      check("hb_256", 64'({HBLANK, VBLANK, R, G, B}), 64'({2'b10, 24'h0}));

      // Offset -8 (latched at frame 1 start); a mid-frame change must not apply.
      HOFFS = 4'h7;
      scan_line(1, first, cnt);
      check("hs_start_m8", 64'(first), 64'd272);
      check("hs_len_m8", 64'(cnt), 64'd32);

      // Vertical blanking boundary.
      wait_pos(0, 3);
      tick();
      check("vb_line3", 64'({VBLANK, R, G, B}), 64'({1'b1, 24'h0}));
      check("vs_line3", 64'(VSYNC), 64'd1);

      // Frame 2 picks up offset +7.
      scan_line(0, first, cnt);
      check("hs_start_p7", 64'(first), 64'd332);
      check("hs_len_p7", 64'(cnt), 64'd32);

      // Reset in the middle of HSYNC on a VSYNC line.
      wait_pos(340, 4);
      tick();
      check("pre_reset_syncs", 64'({HSYNC, VSYNC}), 64'b11);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_clear", 64'({PH, PV, CE_PIX, R, G, B, HBLANK, VBLANK, HSYNC, VSYNC}), 64'd0);
      repeat (3) @(posedge clk48M);
      @(negedge clk48M);
      reset_n = 1'b1;
      repeat (7) tick();
      check("restart_ce", 64'({CE_PIX, PH, PV}), 64'({1'b1, 18'd0}));
      tick();
      check("restart_ph", 64'({PH, PV}), 64'({9'd1, 9'd0}));

      // Reset cleared the latched offset: back to the nominal 304.
      scan_line(1, first, cnt);
      check("hs_start_rst", 64'(first), 64'd304);
      check("hs_len_rst", 64'(cnt), 64'd32);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
